// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the instruction field positions used by the hazard unit and decoders, the
// reset defaults, and the packed layout of one stage register.
package pipe_stage_regs_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int STAGE_W = INSTR_W + PC_W;

    // Instruction field positions.
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    // sll $0,$0,0 is the canonical bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC8_RST_DEF   = 32'h0000_3008;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc8;
    } stage_t;

    function automatic logic [5:0] op_field(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    function automatic logic [5:0] funct_field(input logic [INSTR_W-1:0] instr);
        return instr[FUNCT_HI:FUNCT_LO];
    endfunction

    function automatic logic [4:0] rs_field(input logic [INSTR_W-1:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_field(input logic [INSTR_W-1:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] rd_field(input logic [INSTR_W-1:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/pipe_stage_regs_pipe_reg.sv
// One pipeline stage register (instruction word + PC+8).
// Reset loads rst_val; en=0 holds; clr loads the bubble value instead of d.
module pipe_reg
    import pipe_stage_regs_pkg::*;
#(
    parameter int W = STAGE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] clr_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage storage: reset beats hold, hold beats bubble, bubble beats advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= rst_val;
        end else if (en) begin
            if (clr) begin
                q <= clr_val;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D, D/E, E/M and M/W registers of the 5-stage MIPS core.
// A hazard stall freezes F/D and drops a bubble into D/E (keeping PC+8 of the
// stalled instruction so link data stays traceable); a debug freeze holds
// everything. Saturating stall and retire counters support performance debug.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter int           CNT_W     = 32,
    parameter logic [31:0]  NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [31:0]  PC8_RST   = PC8_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             freeze,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      PC8F,
    output logic [31:0]      InstrD,
    output logic [31:0]      InstrE,
    output logic [31:0]      InstrM,
    output logic [31:0]      InstrW,
    output logic [31:0]      PC8D,
    output logic [31:0]      PC8E,
    output logic [31:0]      PC8M,
    output logic [31:0]      PC8W,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t rst_stage;
    stage_t f_stage;
    stage_t bubble_stage;
    stage_t fd_q;
    stage_t de_q;
    stage_t em_q;
    stage_t mw_q;

    logic fd_en;
    logic adv_en;

    assign rst_stage    = '{instr: NOP_INSTR, pc8: PC8_RST};
    assign f_stage      = '{instr: InstrF, pc8: PC8F};
    // The bubble keeps PC+8 of the instruction held in D.
    assign bubble_stage = '{instr: NOP_INSTR, pc8: fd_q.pc8};

    assign fd_en  = !stall && !freeze;
    assign adv_en = !freeze;

    pipe_reg #(.W(STAGE_W)) u_fd (
        .clk(clk), .reset(reset), .en(fd_en), .clr(1'b0),
        .rst_val(rst_stage), .clr_val(rst_stage), .d(f_stage), .q(fd_q)
    );

    pipe_reg #(.W(STAGE_W)) u_de (
        .clk(clk), .reset(reset), .en(adv_en), .clr(stall),
        .rst_val(rst_stage), .clr_val(bubble_stage), .d(fd_q), .q(de_q)
    );

    pipe_reg #(.W(STAGE_W)) u_em (
        .clk(clk), .reset(reset), .en(adv_en), .clr(1'b0),
        .rst_val(rst_stage), .clr_val(rst_stage), .d(de_q), .q(em_q)
    );

    pipe_reg #(.W(STAGE_W)) u_mw (
        .clk(clk), .reset(reset), .en(adv_en), .clr(1'b0),
        .rst_val(rst_stage), .clr_val(rst_stage), .d(em_q), .q(mw_q)
    );

    assign InstrD = fd_q.instr;
    assign InstrE = de_q.instr;
    assign InstrM = em_q.instr;
    assign InstrW = mw_q.instr;
    assign PC8D   = fd_q.pc8;
    assign PC8E   = de_q.pc8;
    assign PC8M   = em_q.pc8;
    assign PC8W   = mw_q.pc8;

    // Count unfrozen stall cycles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!freeze && stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Count real instructions leaving W (value before the edge), sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (!freeze && (mw_q.instr != NOP_INSTR) && (retire_cnt != CNT_MAX)) begin
            retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

endmodule
